// File: rtl/mig_ui_responder_pkg.sv
// Shared definitions for the MIG user-interface responder: command codes,
// controller state encodings and queue geometry.
package mig_ui_responder_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR0     = 3'd1,
    ST_WR1     = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD0     = 3'd4,
    ST_RD1     = 3'd5
  } mig_state_t;

  localparam int AF_DEPTH  = 4;
  localparam int AF_AFULL  = 3;
  localparam int WDF_DEPTH = 8;
  localparam int WDF_AFULL = 6;
  localparam int LAT_W     = 4;

endpackage

// File: rtl/ui_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy level, almost-full
// flag and a drop indication for pushes that find it full. DEPTH must be 2^n.
module ui_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         afull,
  output logic                         drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign head    = mem[rd_ptr];
  assign level   = count;
  assign afull   = (count >= CNT_W'(AFULL_TH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mig_ui_responder.sv
// Behavioural responder for the MIG user interface: queues commands and write
// beats, executes two-beat bursts in order against a block-RAM burst store.
module mig_ui_responder
  import mig_ui_responder_pkg::*;
#(
  parameter int APPDATA_WIDTH = 128,
  parameter int ADDR_WIDTH    = 31,
  parameter int IDX_W         = 6,
  parameter int RD_LATENCY    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       app_af_wren,
  input  logic [ADDR_WIDTH-1:0]      app_af_addr,
  input  logic [2:0]                 app_af_cmd,
  input  logic                       app_wdf_wren,
  input  logic [APPDATA_WIDTH-1:0]   app_wdf_data,
  input  logic [APPDATA_WIDTH/8-1:0] app_wdf_mask_data,
  output logic                       app_af_afull,
  output logic                       app_wdf_afull,
  output logic                       rd_data_valid,
  output logic [APPDATA_WIDTH-1:0]   rd_data_fifo_out,
  output logic                       cmd_err,
  output logic                       ovf_err
);

  localparam int MASK_W      = APPDATA_WIDTH/8;
  localparam int AF_W        = 3 + ADDR_WIDTH;
  localparam int WDF_W       = MASK_W + APPDATA_WIDTH;
  localparam int STORE_DEPTH = 2**(IDX_W+1);

  logic [AF_W-1:0]                   af_head;
  logic [$clog2(AF_DEPTH+1)-1:0]     af_level;
  logic                              af_pop;
  logic                              af_drop;
  logic [WDF_W-1:0]                  wdf_head;
  logic [$clog2(WDF_DEPTH+1)-1:0]    wdf_level;
  logic                              wdf_pop;
  logic                              wdf_drop;

  logic [2:0]               head_cmd;
  logic [IDX_W-1:0]         head_slot;
  logic [MASK_W-1:0]        wr_mask;
  logic [APPDATA_WIDTH-1:0] wr_data;

  mig_state_t               state;
  logic [LAT_W-1:0]         lat_cnt;
  logic [IDX_W-1:0]         slot;
  logic [IDX_W:0]           waddr;
  logic [IDX_W:0]           raddr;
  logic                     rd_fire;

  logic [APPDATA_WIDTH-1:0] store [STORE_DEPTH];

  ui_sync_fifo #(
    .WIDTH    (AF_W),
    .DEPTH    (AF_DEPTH),
    .AFULL_TH (AF_AFULL)
  ) u_af_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (app_af_wren),
    .push_data ({app_af_cmd, app_af_addr}),
    .pop       (af_pop),
    .head      (af_head),
    .level     (af_level),
    .afull     (app_af_afull),
    .drop      (af_drop)
  );

  ui_sync_fifo #(
    .WIDTH    (WDF_W),
    .DEPTH    (WDF_DEPTH),
    .AFULL_TH (WDF_AFULL)
  ) u_wdf_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (app_wdf_wren),
    .push_data ({app_wdf_mask_data, app_wdf_data}),
    .pop       (wdf_pop),
    .head      (wdf_head),
    .level     (wdf_level),
    .afull     (app_wdf_afull),
    .drop      (wdf_drop)
  );

  assign head_cmd  = af_head[AF_W-1 -: 3];
  assign head_slot = af_head[IDX_W+1:2];
  assign wr_mask   = wdf_head[WDF_W-1 -: MASK_W];
  assign wr_data   = wdf_head[APPDATA_WIDTH-1:0];

  // A write waits at the head until both of its beats are queued.
  assign af_pop  = (state == ST_IDLE) && (af_level != '0) &&
                   ((head_cmd != CMD_WR) || (wdf_level >= 2));
  assign wdf_pop = (state == ST_WR0) || (state == ST_WR1);
  assign waddr   = {slot, (state == ST_WR1)};
  assign rd_fire = ((state == ST_RD_WAIT) && (lat_cnt == '0)) || (state == ST_RD0);
  assign raddr   = {slot, (state == ST_RD0)};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      lat_cnt       <= '0;
      cmd_err       <= 1'b0;
      ovf_err       <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      rd_data_valid <= rd_fire;
      if (af_drop || wdf_drop) ovf_err <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (af_pop) begin
            slot <= head_slot;
            if (head_cmd == CMD_WR) begin
              state <= ST_WR0;
            end else if (head_cmd == CMD_RD) begin
              lat_cnt <= LAT_W'(RD_LATENCY - 1);
              state   <= ST_RD_WAIT;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        ST_WR0:     state <= ST_WR1;
        ST_WR1:     state <= ST_IDLE;
        ST_RD_WAIT: begin
          if (lat_cnt == '0) state <= ST_RD0;
          else               lat_cnt <= lat_cnt - LAT_W'(1);
        end
        ST_RD0:     state <= ST_RD1;
        ST_RD1:     state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  // Store write port: byte-enabled, one beat per WR state.
  always_ff @(posedge clk) begin
    if (wdf_pop) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wr_mask[b]) store[waddr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Store read port doubles as the output register; holds between bursts.
  always_ff @(posedge clk) begin
    if (rst)          rd_data_fifo_out <= '0;
    else if (rd_fire) rd_data_fifo_out <= store[raddr];
  end

endmodule

// File: tb/tb_mig_ui_responder.sv
// Scoreboard bench for mig_ui_responder: expected read beats are queued at
// issue time and a negedge monitor compares every beat the DUT presents.
module tb_mig_ui_responder;
  import mig_ui_responder_pkg::*;

  localparam int DW  = 128;
  localparam int AW  = 31;
  localparam int IW  = 6;
  localparam int LAT = 4;
  localparam int MW  = DW/8;

  localparam logic [DW-1:0] BEAT_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] BEAT_B = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;
  localparam logic [DW-1:0] ONES   = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [DW-1:0] KEEP_LO = 128'h00000000_00000000_00000000_000000FF;
  localparam logic [DW-1:0] KEEP_HI = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          app_af_wren = 1'b0;
  logic [AW-1:0] app_af_addr = '0;
  logic [2:0]    app_af_cmd = '0;
  logic          app_wdf_wren = 1'b0;
  logic [DW-1:0] app_wdf_data = '0;
  logic [MW-1:0] app_wdf_mask_data = '0;
  logic          app_af_afull;
  logic          app_wdf_afull;
  logic          rd_data_valid;
  logic [DW-1:0] rd_data_fifo_out;
  logic          cmd_err;
  logic          ovf_err;

  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            lat_start = -1;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  mig_ui_responder #(
    .APPDATA_WIDTH (DW),
    .ADDR_WIDTH    (AW),
    .IDX_W         (IW),
    .RD_LATENCY    (LAT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .app_af_wren       (app_af_wren),
    .app_af_addr       (app_af_addr),
    .app_af_cmd        (app_af_cmd),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask_data (app_wdf_mask_data),
    .app_af_afull      (app_af_afull),
    .app_wdf_afull     (app_wdf_afull),
    .rd_data_valid     (rd_data_valid),
    .rd_data_fifo_out  (rd_data_fifo_out),
    .cmd_err           (cmd_err),
    .ovf_err           (ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented beat must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && rd_data_valid) begin
      if (lat_start >= 0) begin
        check_int("read_latency", cyc - lat_start, LAT + 1);
        lat_start = -1;
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected no beat", rd_data_fifo_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rd_beat", rd_data_fifo_out, mon_exp);
      end
    end
  end

  function automatic logic [AW-1:0] slot_addr(input int s);
    return AW'(s) << 2;
  endfunction

  function automatic logic [DW-1:0] pat(input int k);
    return {4{32'hC0DE_0000 | 32'(k)}};
  endfunction

  task automatic push_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    app_af_wren = 1'b1;
    app_af_cmd  = c;
    app_af_addr = a;
    @(negedge clk);
    app_af_wren = 1'b0;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [MW-1:0] m);
    app_wdf_wren      = 1'b1;
    app_wdf_data      = d;
    app_wdf_mask_data = m;
    @(negedge clk);
    app_wdf_wren = 1'b0;
  endtask

  task automatic push_rd(input logic [AW-1:0] a, input logic [DW-1:0] e0,
                         input logic [DW-1:0] e1, input bit timed);
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    push_cmd(CMD_RD, a);
    if (timed) lat_start = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check_int("drain_outstanding", exp_q.size(), 0);
    idle(3);
  endtask

  initial begin
    idle(3);
    check("rst_af_afull", app_af_afull, 0);
    check("rst_wdf_afull", app_wdf_afull, 0);
    check("rst_valid", rd_data_valid, 0);
    check("rst_data", rd_data_fifo_out, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_ovf_err", ovf_err, 0);
    rst = 1'b0;
    idle(2);

    // Basic write/read of slot 5; read address has stray low/high bits set.
    push_cmd(CMD_WR, slot_addr(5));
    push_beat(BEAT_A, '0);
    push_beat(BEAT_B, '0);
    idle(8);
    push_rd(slot_addr(5) | 31'h0010_0003, BEAT_A, BEAT_B, 1'b1);
    drain();
    check("hold_after_read", rd_data_fifo_out, BEAT_B);
    check("valid_low_after_read", rd_data_valid, 0);

    // Byte masks: a set mask bit preserves that byte.
    push_cmd(CMD_WR, slot_addr(3));
    push_beat(ONES, '0);
    push_beat(ONES, '0);
    push_cmd(CMD_WR, slot_addr(3));
    push_beat('0, 16'h0001);
    push_beat('0, '0);
    push_cmd(CMD_WR, slot_addr(4));
    push_beat(ONES, '0);
    push_beat(ONES, '0);
    push_cmd(CMD_WR, slot_addr(4));
    push_beat('0, 16'hFFFE);
    push_beat('0, '0);
    idle(12);
    push_rd(slot_addr(3), KEEP_LO, '0, 1'b0);
    push_rd(slot_addr(4), KEEP_HI, '0, 1'b0);
    drain();

    // Data queued ahead of commands fills the write-data FIFO.
    for (int k = 1; k <= 6; k++) push_beat(pat(k), '0);
    check("wdf_afull_six_beats", app_wdf_afull, 1);
    check("af_afull_no_cmds", app_af_afull, 0);
    for (int s = 10; s <= 12; s++) push_cmd(CMD_WR, slot_addr(s));
    idle(15);
    check("wdf_afull_drained", app_wdf_afull, 0);
    check("af_afull_drained_a", app_af_afull, 0);
    for (int s = 10; s <= 12; s++)
      push_rd(slot_addr(s), pat(2*(s-10)+1), pat(2*(s-10)+2), 1'b0);
    drain();

    // Commands queued ahead of data stall at the head.
    for (int s = 13; s <= 15; s++) push_cmd(CMD_WR, slot_addr(s));
    check("af_afull_three_cmds", app_af_afull, 1);
    check("wdf_afull_no_data", app_wdf_afull, 0);
    idle(10);
    check("af_afull_still_stalled", app_af_afull, 1);
    for (int k = 7; k <= 12; k++) push_beat(pat(k), '0);
    idle(15);
    check("af_afull_drained_b", app_af_afull, 0);
    check("wdf_afull_drained_b", app_wdf_afull, 0);
    for (int s = 13; s <= 15; s++)
      push_rd(slot_addr(s), pat(2*(s-13)+7), pat(2*(s-13)+8), 1'b0);
    drain();

    // Illegal command is discarded; the following read still executes.
    check("cmd_err_before", cmd_err, 0);
    push_cmd(3'b010, slot_addr(5));
    push_rd(slot_addr(5), BEAT_A, BEAT_B, 1'b0);
    drain();
    check("cmd_err_set", cmd_err, 1);

    // Fifth command into a stalled, full address FIFO is dropped.
    check("ovf_err_before", ovf_err, 0);
    for (int s = 20; s <= 23; s++) push_cmd(CMD_WR, slot_addr(s));
    push_cmd(CMD_RD, slot_addr(5));
    check("ovf_err_set", ovf_err, 1);
    check("af_afull_full", app_af_afull, 1);
    for (int k = 13; k <= 20; k++) push_beat(pat(k), '0);
    idle(20);
    for (int s = 20; s <= 23; s++)
      push_rd(slot_addr(s), pat(2*(s-20)+13), pat(2*(s-20)+14), 1'b0);
    drain();
    idle(10);

    // Reset during the read latency aborts the burst; the store survives.
    push_cmd(CMD_RD, slot_addr(5));
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("mid_rst_valid", rd_data_valid, 0);
    check("mid_rst_data", rd_data_fifo_out, 0);
    check("mid_rst_cmd_err", cmd_err, 0);
    check("mid_rst_ovf_err", ovf_err, 0);
    check("mid_rst_af_afull", app_af_afull, 0);
    check("mid_rst_wdf_afull", app_wdf_afull, 0);
    idle(15);
    push_rd(slot_addr(5), BEAT_A, BEAT_B, 1'b0);
    drain();

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
